vga_pattern_gen: RTL and testbench

- Pixel-generation stage directly downstream of the hsync/vsync timing generators in the VGA path.
- Consumes raw sync and blank strobes, rebuilds pixel x/y coordinates and a frame count, and drives 1-bit RGB test patterns.
- Delays the syncs by the same pipeline depth as the colour path, so sync and colour leave the block aligned and go straight to the pins.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_pix_counter.sv | 87 ++++++++
 rtl/vga_pattern_gen.sv | 131 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path.
// Holds the pattern-mode encodings, the 640x480@60 timing constants, the
// 1-bit RGB colour constants and the stage-1 resync FSM state type.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_GRID   = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  // Stage-1 resync after reset: wait for vblank, then for its falling edge.
  typedef enum logic [1:0] {
    SYNC_WAIT_VB   = 2'd0,
    SYNC_WAIT_FALL = 2'd1,
    SYNC_RUN       = 2'd2
  } sync_st_e;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = 525;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_WHITE = 3'b111;

endpackage

// File: rtl/vga_pix_counter.sv
// Stage-1 pixel counters: rebuilds x/y from the blank strobes, counts frames,
// and produces the registered active and frame_start flags.
// Ports:
//   i_clk, i_rst_n      pixel clock, synchronous active-low reset
//   i_hblank, i_vblank  raw blank strobes
//   o_x, o_y            stage-1 coordinates (saturating)
//   o_frame             8-bit frame counter, +1 on each vblank rise
//   o_active            registered active flag
//   o_frame_start       registered first-pixel-of-frame flag
//   o_vblank_rise       combinational vblank rising-edge strobe (current sample)
module vga_pix_counter
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hblank,
  input  logic             i_vblank,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic [7:0]       o_frame,
  output logic             o_active,
  output logic             o_frame_start,
  output logic             o_vblank_rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sync_st_e         st_q;
  logic             hb_prev_q, vb_prev_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]       frame_q;
  logic             active_q, fs_q;
  logic             run, hb_rise, vb_rise, active_d;

  always_comb begin
    // Counting restarts on the very sample where vblank falls.
    run      = (st_q == SYNC_RUN) || ((st_q == SYNC_WAIT_FALL) && !i_vblank);
    hb_rise  = i_hblank && !hb_prev_q;
    vb_rise  = i_vblank && !vb_prev_q;
    // x of the current sample: 0 on the first sample after hblank falls.
    x_d = '0;
    if (run && !i_hblank && !hb_prev_q)
      x_d = (x_q == CNT_MAX) ? x_q : x_q + 1'b1;
    y_d = '0;
    if (run && !i_vblank)
      y_d = (hb_rise && (y_q != CNT_MAX)) ? y_q + 1'b1 : y_q;
    active_d = run && !i_hblank && !i_vblank;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st_q      <= SYNC_WAIT_VB;
      // Edge detectors take the reset-cycle sample so no edge is invented
      // or lost across reset.
      hb_prev_q <= i_hblank;
      vb_prev_q <= i_vblank;
      x_q       <= '0;
      y_q       <= '0;
      frame_q   <= '0;
      active_q  <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      case (st_q)
        SYNC_WAIT_VB:   if (i_vblank)  st_q <= SYNC_WAIT_FALL;
        SYNC_WAIT_FALL: if (!i_vblank) st_q <= SYNC_RUN;
        default:        st_q <= SYNC_RUN;
      endcase
      hb_prev_q <= i_hblank;
      vb_prev_q <= i_vblank;
      x_q       <= x_d;
      y_q       <= y_d;
      if (vb_rise) frame_q <= frame_q + 8'd1;
      active_q  <= active_d;
      fs_q      <= active_d && (x_d == '0) && (y_d == '0);
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame       = frame_q;
  assign o_active      = active_q;
  assign o_frame_start = fs_q;
  assign o_vblank_rise = vb_rise;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: two-stage pipeline (counters, colour) with a
// matching 2-flop sync delay so syncs and colour leave aligned.
// Ports:
//   i_clk, i_rst_n            pixel clock, synchronous active-low reset
//   i_hsync, i_vsync          raw syncs, delayed 2 cycles to o_hsync/o_vsync
//   i_hblank, i_vblank        blank strobes, decide what is active
//   i_next_mode               one-cycle request, applied at next vblank rise
//   o_red, o_grn, o_blu       1-bit colour
//   o_x, o_y                  coordinates of the output pixel
//   o_mode                    pattern of the output pixel
//   o_frame_start             pulse on the first active pixel of a frame
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned BAR_W      = 80,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter bit          SYNC_IDLE  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_hblank,
  input  logic             i_vblank,
  input  logic             i_next_mode,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_red,
  output logic             o_grn,
  output logic             o_blu,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic [1:0]       o_mode,
  output logic             o_frame_start
);

  localparam int unsigned XW = CNT_W + 1;

  logic [CNT_W-1:0] x1, y1;
  logic [7:0]       frame1;
  logic             active1, fs1, vb_rise;

  vga_pix_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_hblank      (i_hblank),
    .i_vblank      (i_vblank),
    .o_x           (x1),
    .o_y           (y1),
    .o_frame       (frame1),
    .o_active      (active1),
    .o_frame_start (fs1),
    .o_vblank_rise (vb_rise)
  );

  mode_e            mode_q;
  logic             pend_q, pend_now;
  logic             hs1_q, vs1_q, hs2_q, vs2_q;
  logic [2:0]       rgb_d, rgb_q;
  logic [CNT_W-1:0] x2_q, y2_q, bar_idx;
  logic [1:0]       mode2_q;
  logic             fs2_q;
  logic [XW-1:0]    x_ext, lo, hi;

  // A request in the same cycle as the vblank rise counts for that rise.
  assign pend_now = pend_q || i_next_mode;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_q <= MODE_BARS;
      pend_q <= 1'b0;
    end else if (vb_rise) begin
      if (pend_now) mode_q <= mode_e'(mode_q + 2'd1);
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_now;
    end
  end

  always_comb begin
    bar_idx = x1 / CNT_W'(BAR_W);
    x_ext   = {1'b0, x1};
    lo      = XW'({frame1, 1'b0});
    hi      = lo + XW'(15);
    rgb_d   = RGB_BLACK;
    case (mode_q)
      MODE_BARS:   rgb_d = (bar_idx > CNT_W'(7)) ? RGB_BLACK : RGB_WHITE - bar_idx[2:0];
      MODE_CHECK:  rgb_d = (x1[CHECK_LOG2] ^ y1[CHECK_LOG2]) ? RGB_WHITE : RGB_BLACK;
      MODE_GRID:   rgb_d = ((x1[3:0] == '0) || (y1[3:0] == '0)) ? RGB_WHITE : RGB_BLUE;
      MODE_SCROLL: rgb_d = ((x_ext >= lo) && (x_ext <= hi)) ? RGB_RED : RGB_BLACK;
      default:     rgb_d = RGB_BLACK;
    endcase
    if (!active1) rgb_d = RGB_BLACK;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hs1_q   <= SYNC_IDLE;
      vs1_q   <= SYNC_IDLE;
      hs2_q   <= SYNC_IDLE;
      vs2_q   <= SYNC_IDLE;
      rgb_q   <= RGB_BLACK;
      x2_q    <= '0;
      y2_q    <= '0;
      mode2_q <= '0;
      fs2_q   <= 1'b0;
    end else begin
      hs1_q   <= i_hsync;
      vs1_q   <= i_vsync;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      rgb_q   <= rgb_d;
      x2_q    <= x1;
      y2_q    <= y1;
      mode2_q <= mode_q;
      fs2_q   <= fs1;
    end
  end

  assign o_hsync       = hs2_q;
  assign o_vsync       = vs2_q;
  assign o_red         = rgb_q[2];
  assign o_grn         = rgb_q[1];
  assign o_blu         = rgb_q[0];
  assign o_x           = x2_q;
  assign o_y           = y2_q;
  assign o_mode        = mode2_q;
  assign o_frame_start = fs2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized scoreboard bench for vga_pattern_gen. The driver walks frames of
// configurable geometry, computes each sample's expected output from the
// pattern rules and queues it; the monitor pops on the due cycle and compares.
module tb_vga_pattern_gen;

  localparam int CNT_W = 12;
  localparam int BAR_W = 80;
  localparam int CHK   = 32;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0, i_hsync = 1'b1, i_vsync = 1'b1;
  logic             i_hblank = 1'b1, i_vblank = 1'b1, i_next_mode = 1'b0;
  logic             o_hsync, o_vsync, o_red, o_grn, o_blu, o_frame_start;
  logic [CNT_W-1:0] o_x, o_y;
  logic [1:0]       o_mode;

  vga_pattern_gen #(
    .CNT_W(CNT_W), .BAR_W(BAR_W), .CHECK_LOG2(5), .SYNC_IDLE(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_hblank(i_hblank), .i_vblank(i_vblank), .i_next_mode(i_next_mode),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_red(o_red), .o_grn(o_grn),
    .o_blu(o_blu), .o_x(o_x), .o_y(o_y), .o_mode(o_mode),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned      due;
    logic             hs, vs, fs;
    logic [2:0]       rgb;
    logic [CNT_W-1:0] x, y;
    logic [1:0]       mode;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;

  // Reference state: frames seen since reset, mode, pending request, resync.
  int m_frame = 0, m_mode = 0;
  bit m_pend = 0, m_seen_vb = 0, m_synced = 0, m_prev_vb = 1;

  function automatic logic [2:0] colour(input int mode, input int x, input int y, input int frame);
    int bar;
    case (mode)
      0: begin
        bar = x / BAR_W;
        if (bar > 7) bar = 7;
        return 3'(7 - bar);
      end
      1: return ((((x / CHK) + (y / CHK)) % 2) == 1) ? 3'b111 : 3'b000;
      2: return ((x % 16 == 0) || (y % 16 == 0)) ? 3'b111 : 3'b001;
      default: return ((x >= 2 * frame) && (x <= 2 * frame + 15)) ? 3'b100 : 3'b000;
    endcase
  endfunction

  // Monitor: compare every queued expectation on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_tests++;
      if (o_hsync !== e.hs || o_vsync !== e.vs || {o_red, o_grn, o_blu} !== e.rgb ||
          o_x !== e.x || o_y !== e.y || o_mode !== e.mode || o_frame_start !== e.fs) begin
        n_fail++;
        $display("FAIL pix cyc=%0d got hs=%b vs=%b rgb=%b x=%0d y=%0d mode=%0d fs=%b need hs=%b vs=%b rgb=%b x=%0d y=%0d mode=%0d fs=%b",
                 cyc, o_hsync, o_vsync, {o_red, o_grn, o_blu}, o_x, o_y, o_mode, o_frame_start,
                 e.hs, e.vs, e.rgb, e.x, e.y, e.mode, e.fs);
      end
    end
  end

  task automatic drive(input bit rst, input bit hbv, input bit vbv, input bit pulse,
                       input int col, input int line);
    exp_t e, p;
    bit   rise, active;
    int   xi, yi;
    @(posedge clk);
    #1;
    i_rst_n     = !rst;
    i_hblank    = hbv;
    i_vblank    = vbv;
    i_next_mode = pulse;
    i_hsync     = 1'($urandom_range(0, 1));
    i_vsync     = 1'($urandom_range(0, 1));
    e.due = cyc + 2;
    if (rst) begin
      m_frame = 0; m_mode = 0; m_pend = 0; m_seen_vb = 0; m_synced = 0;
      e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.rgb = 3'b000;
      e.x = '0; e.y = '0; e.mode = 2'd0;
      // Reset also wipes the pixel still in the colour stage.
      if (q.size() > 0 && q[q.size()-1].due == cyc + 1) begin
        p = q.pop_back();
        p.hs = 1'b1; p.vs = 1'b1; p.fs = 1'b0; p.rgb = 3'b000;
        p.x = '0; p.y = '0; p.mode = 2'd0;
        q.push_back(p);
      end
    end else begin
      rise   = vbv && !m_prev_vb;
      m_pend = m_pend || pulse;
      if (rise) begin
        m_frame = (m_frame + 1) % 256;
        if (m_pend) m_mode = (m_mode + 1) % 4;
        m_pend = 0;
      end
      if (!m_synced && m_seen_vb && !vbv) m_synced = 1;
      if (vbv) m_seen_vb = 1;
      active = m_synced && !hbv && !vbv;
      xi = (m_synced && !hbv) ? col : 0;
      yi = (m_synced && !vbv) ? line + int'(hbv) : 0;
      e.hs   = i_hsync;
      e.vs   = i_vsync;
      e.rgb  = active ? colour(m_mode, xi, yi, m_frame) : 3'b000;
      e.fs   = active && xi == 0 && yi == 0;
      e.x    = CNT_W'(xi);
      e.y    = CNT_W'(yi);
      e.mode = 2'(m_mode);
    end
    m_prev_vb = vbv;
    q.push_back(e);
  endtask

  task automatic vlines(input int n, input int ha, input int hbl);
    for (int l = 0; l < n; l++)
      for (int c = 0; c < ha + hbl; c++)
        drive(1'b0, c >= ha, 1'b1, 1'b0, c, l);
  endtask

  // One frame: va active lines then vbl vblank lines; npulse random requests
  // inside the active lines, optional request on the vblank-rise sample,
  // optional one-cycle reset on line rst_line.
  task automatic frame(input int ha, input int hbl, input int va, input int vbl,
                       input int npulse, input bit rise_pulse, input int rst_line);
    int pidx[4];
    int idx, rst_col;
    bit p;
    for (int i = 0; i < 4; i++)
      pidx[i] = (i < npulse) ? int'($urandom_range(0, va * (ha + hbl) - 1)) : -1;
    rst_col = int'($urandom_range(0, ha + hbl - 1));
    idx = 0;
    for (int l = 0; l < va + vbl; l++)
      for (int c = 0; c < ha + hbl; c++) begin
        p = 1'b0;
        for (int i = 0; i < 4; i++) if (pidx[i] == idx) p = 1'b1;
        if (rise_pulse && l == va && c == 0) p = 1'b1;
        drive(l == rst_line && c == rst_col, c >= ha, l >= va, p, c, l);
        idx++;
      end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got no finish, need finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for 5 cycles with toggling inputs; outputs must stay idle.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    vlines(2, 640, 8);
    frame(640, 8, 2, 2, 3, 1'b0, -1);  // BARS, three requests -> CHECK
    frame(40, 8, 34, 2, 0, 1'b1, -1);  // CHECK, request on the rise -> GRID
    frame(40, 8, 34, 2, 1, 1'b0, -1);  // GRID -> SCROLL
    frame(32, 4, 3, 2, 0, 1'b0, -1);   // SCROLL with frame counter 3
    for (int f = 0; f < 252; f++)
      frame(int'($urandom_range(2, 6)), 2, 2, 1, 0, 1'b0, -1);
    frame(32, 4, 3, 2, 1, 1'b0, -1);   // counter wrapped to 0; -> BARS
    frame(90, 4, 210, 2, int'($urandom_range(0, 2)), 1'b0, 200);  // reset mid-frame
    frame(100, 4, 4, 2, 2, 1'b0, -1);
    frame(40, 8, 34, 2, 0, 1'b0, -1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
